// File: rtl/fifo_wr_if.sv
// Requester-side valid/ready bus plus the shared FIFO write port seen by the write arbiter.
interface fifo_wr_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8
) ();
    localparam int unsigned GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          full;
    logic                          w_en;
    logic [DATA_WIDTH-1:0]         w_data;
    logic [GW-1:0]                 grant_id;
    logic                          busy;

    // Requesters and FIFO side.
    modport master (
        output req_valid, req_data, full,
        input  req_ready, w_en, w_data, grant_id, busy
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_data, full,
        output req_ready, w_en, w_data, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters,
// holding each grant for at most BURST_LEN accepted words.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 4
) (
    input logic       clk,
    input logic       rst,
    fifo_wr_if.slave  wr_if
);
    localparam int unsigned GW = $clog2(NUM_REQ);
    localparam int unsigned BW = $clog2(BURST_LEN) + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [GW-1:0] LAST_REQ  = GW'(NUM_REQ - 1);

    logic [0:0]            state_q, state_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [GW-1:0]         last_q, last_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic                  busy_q, busy_d;

    logic [GW-1:0]         sel_c;
    logic                  sel_valid_c;
    logic                  cur_valid_c;
    logic [DATA_WIDTH-1:0] cur_data_c;
    logic                  xfer_c;
    logic [NUM_REQ-1:0]    ready_c;

    // Round-robin pick: first valid above last_q, otherwise wrap to the lowest valid.
    always_comb begin
        sel_c       = '0;
        sel_valid_c = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!sel_valid_c && wr_if.req_valid[i] && (GW'(i) > last_q)) begin
                sel_c       = GW'(i);
                sel_valid_c = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!sel_valid_c && wr_if.req_valid[i] && (GW'(i) <= last_q)) begin
                sel_c       = GW'(i);
                sel_valid_c = 1'b1;
            end
        end
    end

    // Select the grant holder's valid and data.
    always_comb begin
        cur_valid_c = 1'b0;
        cur_data_c  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == grant_q) begin
                cur_valid_c = wr_if.req_valid[i];
                cur_data_c  = wr_if.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Full backpressure is combinational so a word is never written into a full FIFO.
    assign xfer_c = (state_q == GRANT) && cur_valid_c && !wr_if.full;

    always_comb begin
        ready_c = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == grant_q) begin
                ready_c[i] = xfer_c;
            end
        end
    end

    assign wr_if.req_ready = ready_c;
    assign wr_if.w_en      = xfer_c;
    assign wr_if.w_data    = cur_data_c;
    assign wr_if.grant_id  = grant_q;
    assign wr_if.busy      = busy_q;

    // Next-state: grant in IDLE, release on burst exhaustion or requester going idle.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (sel_valid_c) begin
                    grant_d = sel_c;
                    last_d  = sel_c;
                    beat_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!cur_valid_c) begin
                    state_d = IDLE;
                end else if (xfer_c) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == GRANT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_REQ;
            beat_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            busy_q  <= busy_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed requester traffic, expected writes queued
// as {grant_id, data} and checked by an independent write monitor.
module tb_fifo_wr_arbiter;
    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned BL = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_wr_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk   (clk),
        .rst   (rst),
        .wr_if (bus)
    );

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          wr_cnt = 0;
    int          wcyc[32];
    int          fifo_cnt = 0;
    logic [9:0]  sb[$];
    logic [9:0]  sb_e;
    logic [7:0]  src[NR][$];
    logic [NR-1:0] en = '0;
    logic        full_force = 1'b0;
    logic        fifo_mode = 1'b0;
    logic [NR-1:0] acc_q = '0;
    logic        wen_q = 1'b0;

    assign bus.full = full_force | (fifo_mode && (fifo_cnt >= 16));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Requester and FIFO-occupancy model, updated just after each edge.
    always @(posedge clk) begin
        #1;
        if (!fifo_mode) fifo_cnt = 0;
        else if (!rst && wen_q) fifo_cnt = fifo_cnt + 1;
        if (!rst) begin
            for (int i = 0; i < NR; i++)
                if (acc_q[i] && src[i].size() != 0) void'(src[i].pop_front());
        end
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i]       = en[i] && (src[i].size() != 0);
            bus.req_data[i*DW +: DW] = (src[i].size() != 0) ? src[i][0] : 8'h00;
        end
    end

    // Write monitor: every accepted word must match the head of the scoreboard.
    always @(negedge clk) begin
        acc_q <= bus.req_valid & bus.req_ready;
        wen_q <= bus.w_en;
        if (!rst && bus.w_en) begin
            chk("wen_while_full", 32'(bus.full), 32'd0);
            chk("ready_onehot", 32'(bus.req_ready), 32'(1 << bus.grant_id));
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got id=%0d data=%0h expected none", bus.grant_id, bus.w_data);
            end else begin
                sb_e = sb.pop_front();
                chk("wr_id", 32'(bus.grant_id), 32'(sb_e[9:8]));
                chk("wr_data", 32'(bus.w_data), 32'(sb_e[7:0]));
            end
            if (wr_cnt < 32) wcyc[wr_cnt] = cyc;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic load(input int r, input int n, input logic [7:0] base, input bit expect_it);
        for (int j = 0; j < n; j++) begin
            src[r].push_back(base + 8'(j));
            if (expect_it) sb.push_back({2'(r), base + 8'(j)});
        end
    endtask

    task automatic expect_w(input int r, input logic [7:0] d);
        sb.push_back({2'(r), d});
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s: got %0d pending writes expected 0 after %0d cycles", name, sb.size(), budget);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_wr(input string name, input int target, input int budget);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (wr_cnt != target && n < budget);
        chk(name, 32'(wr_cnt), 32'(target));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_wen", 32'(bus.w_en), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;

        // Single requester 2, three words.
        wr_cnt = 0;
        load(2, 3, 8'hA0, 1'b1);
        en = 4'b0100;
        @(posedge clk);
        #2;
        @(negedge clk);
        chk("t1_idle_busy", 32'(bus.busy), 32'd0);
        chk("t1_idle_wen", 32'(bus.w_en), 32'd0);
        @(negedge clk);
        chk("t1_grant_id", 32'(bus.grant_id), 32'd2);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        drain("t1_drain", 20);
        chk("t1_consecutive", 32'(wcyc[2] - wcyc[0]), 32'd2);
        chk("t1_release_busy", 32'(bus.busy), 32'd0);

        // All four requesters, 16 words each, from reset.
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int q = 0; q < 4; q++)
                load(q, 4, 8'(q * 16 + r * 4), 1'b1);
        wr_cnt = 0;
        en = 4'b1111;
        drain("t2_drain", 300);
        chk("t2_first16_span", 32'(wcyc[15] - wcyc[0]), 32'd18);
        chk("t2_total_writes", 32'(wr_cnt), 32'd64);

        // Requester 1 stalled by full for five cycles after its second beat.
        wr_cnt = 0;
        load(1, 4, 8'h10, 1'b1);
        en = 4'b0010;
        wait_wr("t3_two_beats", 2, 20);
        full_force = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_full_wen", 32'(bus.w_en), 32'd0);
            chk("t3_full_ready", 32'(bus.req_ready), 32'd0);
            chk("t3_full_grant", 32'(bus.grant_id), 32'd1);
            chk("t3_full_busy", 32'(bus.busy), 32'd1);
        end
        @(posedge clk);
        #2 full_force = 1'b0;
        drain("t3_drain", 20);
        chk("t3_writes", 32'(wr_cnt), 32'd4);
        chk("t3_release_busy", 32'(bus.busy), 32'd0);

        // Reset mid-burst of requester 3, then all valid: requester 0 first.
        wr_cnt = 0;
        load(3, 4, 8'h30, 1'b0);
        expect_w(3, 8'h30);
        en = 4'b1000;
        wait_wr("t4_one_beat", 1, 20);
        #1;
        chk("t4_wen_before_rst", 32'(bus.w_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("t4_rst_wen", 32'(bus.w_en), 32'd0);
        chk("t4_rst_ready", 32'(bus.req_ready), 32'd0);
        chk("t4_rst_busy", 32'(bus.busy), 32'd0);
        chk("t4_rst_grant", 32'(bus.grant_id), 32'd0);
        chk("t4_sb_empty", 32'(sb.size()), 32'd0);
        for (int i = 0; i < NR; i++) begin
            src[i].delete();
            load(i, 1, 8'(8'h50 + i), 1'b1);
        end
        en = 4'b1111;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drain("t4_drain", 40);

        // last_grant is 3, requesters 1 and 3 valid: 1 wins, then 3.
        load(1, 2, 8'h61, 1'b1);
        load(3, 2, 8'h63, 1'b1);
        drain("t5_drain", 40);

        // 16-deep FIFO model, two requesters with 20 words each, no reads.
        wr_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) expect_w(0, 8'(8'h40 + k * 4 + j));
            for (int j = 0; j < 4; j++) expect_w(1, 8'(8'h80 + k * 4 + j));
        end
        load(0, 20, 8'h40, 1'b0);
        load(1, 20, 8'h80, 1'b0);
        fifo_mode = 1'b1;
        en = 4'b0011;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.full) chk("t6_wen_when_full", 32'(bus.w_en), 32'd0);
        end
        chk("t6_writes", 32'(wr_cnt), 32'd16);
        chk("t6_fifo_cnt", 32'(fifo_cnt), 32'd16);
        chk("t6_full", 32'(bus.full), 32'd1);
        chk("t6_ready", 32'(bus.req_ready), 32'd0);
        chk("t6_busy", 32'(bus.busy), 32'd1);
        chk("t6_grant", 32'(bus.grant_id), 32'd0);
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);
        chk("t6_left0", 32'(src[0].size()), 32'd12);
        chk("t6_left1", 32'(src[1].size()), 32'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
